// File: rtl/torus_pkg.sv
// Shared types for the torus NoC switches: message layout, route codes and
// the dimension-order routing decision (X ring first, then exit south).
package torus_pkg;

  localparam int TORUS_X_W = 2;
  localparam int TORUS_Y_W = 2;
  localparam int TORUS_D_W = 32;

  typedef struct packed {
    logic [TORUS_X_W-1:0] x;
    logic [TORUS_Y_W-1:0] y;
    logic [TORUS_D_W-1:0] data;
  } msg_t;

  typedef enum logic [1:0] {R_NONE, R_EAST, R_SOUTH} route_e;

  // Traffic keeps travelling east until it reaches its column, then turns south.
  function automatic route_e dor_route(input logic v, input logic [31:0] dest_x,
                                       input logic [31:0] here_x);
    if (!v) return R_NONE;
    return (dest_x != here_x) ? R_EAST : R_SOUTH;
  endfunction

endpackage

// File: rtl/torus_fifo.sv
// Synchronous FIFO for the west input link; power-of-two depth, the count
// (one bit wider than the pointers) tells full from empty.
module torus_fifo #(
  parameter int W     = 36,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_din,
  output logic [W-1:0]             o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_dout  = r_mem[r_rd];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      if (w_push && !w_pop)      r_cnt <= r_cnt + CW'(1);
      else if (w_pop && !w_push) r_cnt <= r_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_din;
  end

endmodule

// File: rtl/torus_switch_fifo_bp.sv
// Backpressured torus switch: registered north input, west FIFO, PE injection,
// dimension-order routing. Optional macro TORUS_SW_INJ_BOOST_EN adds starvation boost for I.
module torus_switch_fifo_bp
  import torus_pkg::*;
#(
  parameter int X_W          = 2,
  parameter int Y_W          = 2,
  parameter int D_W          = 32,
  parameter int X            = 0,
  parameter int Y            = 0,
  parameter int W_DEPTH      = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       n_in_v,
  input  logic [X_W-1:0]             n_in_x,
  input  logic [Y_W-1:0]             n_in_y,
  input  logic [D_W-1:0]             n_in_data,
  input  logic                       w_in_v,
  input  logic [X_W-1:0]             w_in_x,
  input  logic [Y_W-1:0]             w_in_y,
  input  logic [D_W-1:0]             w_in_data,
  input  logic                       i_v,
  input  logic [X_W-1:0]             i_x,
  input  logic [Y_W-1:0]             i_y,
  input  logic [D_W-1:0]             i_data,
  input  logic                       e_b,
  output logic                       w_b,
  output logic                       i_ack,
  output logic                       o_v,
  output logic                       s_out_v,
  output logic [X_W-1:0]             s_out_x,
  output logic [Y_W-1:0]             s_out_y,
  output logic [D_W-1:0]             s_out_data,
  output logic                       e_out_v,
  output logic [X_W-1:0]             e_out_x,
  output logic [Y_W-1:0]             e_out_y,
  output logic [D_W-1:0]             e_out_data,
  output logic [$clog2(W_DEPTH):0]   w_occ,
  output logic                       done
);

  // Instance-width counterpart of torus_pkg::msg_t.
  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [D_W-1:0] data;
  } node_msg_t;

  logic      r_n_v;
  node_msg_t r_n_msg;
  node_msg_t w_w_in, w_w_head, w_i_msg, w_s_msg, w_e_msg;
  logic      w_w_empty, w_w_full, w_w_pop, w_boost;
  route_e    w_w_route, w_i_route;
  logic      w_s_v, w_e_v, w_e_sel_w, w_e_sel_i, w_s_sel_w, w_s_sel_i;

  assign w_w_in  = '{x: w_in_x, y: w_in_y, data: w_in_data};
  assign w_i_msg = '{x: i_x, y: i_y, data: i_data};

  torus_fifo #(.W($bits(node_msg_t)), .DEPTH(W_DEPTH)) u_w_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_in_v && !w_b),
    .i_pop   (w_w_pop),
    .i_din   (w_w_in),
    .o_dout  (w_w_head),
    .o_full  (w_w_full),
    .o_empty (w_w_empty),
    .o_count (w_occ)
  );

  assign w_b       = w_w_full;
  assign w_w_route = dor_route(!w_w_empty, 32'(w_w_head.x), 32'(X));
  assign w_i_route = dor_route(i_v, 32'(i_x), 32'(X));

`ifdef TORUS_SW_INJ_BOOST_EN
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  logic [SC_W-1:0] r_starve;

  always_ff @(posedge clk) begin
    if (!rst_n || !i_v || i_ack) r_starve <= '0;
    else if (r_starve != SC_W'(STARVE_LIMIT)) r_starve <= r_starve + SC_W'(1);
  end

  assign w_boost = (r_starve == SC_W'(STARVE_LIMIT));
`else
  logic w_unused_starve;
  assign w_unused_starve = (STARVE_LIMIT == 0);
  assign w_boost = 1'b0;
`endif

  // Arbitration: east is W over I, south is N over W over I; boost lifts I above W.
  always_comb begin
    w_e_sel_w = 1'b0;
    w_e_sel_i = 1'b0;
    w_s_sel_w = 1'b0;
    w_s_sel_i = 1'b0;
    if (!e_b) begin
      if (w_boost && w_i_route == R_EAST) w_e_sel_i = 1'b1;
      else if (w_w_route == R_EAST)       w_e_sel_w = 1'b1;
      else if (w_i_route == R_EAST)       w_e_sel_i = 1'b1;
    end
    if (!r_n_v) begin
      if (w_boost && w_i_route == R_SOUTH) w_s_sel_i = 1'b1;
      else if (w_w_route == R_SOUTH)       w_s_sel_w = 1'b1;
      else if (w_i_route == R_SOUTH)       w_s_sel_i = 1'b1;
    end
    w_e_v   = w_e_sel_w | w_e_sel_i;
    w_e_msg = w_e_sel_w ? w_w_head : w_i_msg;
    w_s_v   = r_n_v | w_s_sel_w | w_s_sel_i;
    w_s_msg = r_n_v ? r_n_msg : (w_s_sel_w ? w_w_head : w_i_msg);
  end

  assign w_w_pop = w_e_sel_w | w_s_sel_w;
  assign i_ack   = w_e_sel_i | w_s_sel_i;

  // Output stage: south loads every edge, east only while the neighbour accepts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_n_v      <= 1'b0;
      r_n_msg    <= '0;
      s_out_v    <= 1'b0;
      s_out_x    <= '0;
      s_out_y    <= '0;
      s_out_data <= '0;
      o_v        <= 1'b0;
      e_out_v    <= 1'b0;
      e_out_x    <= '0;
      e_out_y    <= '0;
      e_out_data <= '0;
    end else begin
      r_n_v      <= n_in_v;
      r_n_msg    <= '{x: n_in_x, y: n_in_y, data: n_in_data};
      s_out_v    <= w_s_v;
      s_out_x    <= w_s_msg.x;
      s_out_y    <= w_s_msg.y;
      s_out_data <= w_s_msg.data;
      o_v        <= w_s_v && (w_s_msg.x == X_W'(X)) && (w_s_msg.y == Y_W'(Y));
      if (!e_b) begin
        e_out_v    <= w_e_v;
        e_out_x    <= w_e_msg.x;
        e_out_y    <= w_e_msg.y;
        e_out_data <= w_e_msg.data;
      end
    end
  end

  assign done = !(n_in_v | w_in_v | i_v | r_n_v | !w_w_empty | s_out_v | e_out_v | o_v);

endmodule

// File: tb/tb_torus_switch_fifo_bp.sv
// Directed bench for torus_switch_fifo_bp at node (1,1) with a 4-deep west FIFO.
module tb_torus_switch_fifo_bp;

  localparam int X_W = 2, Y_W = 2, D_W = 32;
`ifdef TORUS_SW_INJ_BOOST_EN
  localparam bit BOOST = 1'b1;
`else
  localparam bit BOOST = 1'b0;
`endif

  logic clk, rst_n;
  logic n_in_v, w_in_v, i_v, e_b;
  logic [X_W-1:0] n_in_x, w_in_x, i_x;
  logic [Y_W-1:0] n_in_y, w_in_y, i_y;
  logic [D_W-1:0] n_in_data, w_in_data, i_data;
  logic w_b, i_ack, o_v, s_out_v, e_out_v, done;
  logic [X_W-1:0] s_out_x, e_out_x;
  logic [Y_W-1:0] s_out_y, e_out_y;
  logic [D_W-1:0] s_out_data, e_out_data;
  logic [2:0] w_occ;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] rx[$];
  int pi;

  torus_switch_fifo_bp #(
    .X_W(X_W), .Y_W(Y_W), .D_W(D_W), .X(1), .Y(1), .W_DEPTH(4), .STARVE_LIMIT(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .n_in_v(n_in_v), .n_in_x(n_in_x), .n_in_y(n_in_y), .n_in_data(n_in_data),
    .w_in_v(w_in_v), .w_in_x(w_in_x), .w_in_y(w_in_y), .w_in_data(w_in_data),
    .i_v(i_v), .i_x(i_x), .i_y(i_y), .i_data(i_data),
    .e_b(e_b), .w_b(w_b), .i_ack(i_ack), .o_v(o_v),
    .s_out_v(s_out_v), .s_out_x(s_out_x), .s_out_y(s_out_y), .s_out_data(s_out_data),
    .e_out_v(e_out_v), .e_out_x(e_out_x), .e_out_y(e_out_y), .e_out_data(e_out_data),
    .w_occ(w_occ), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    n_in_v = 1'b0; n_in_x = '0; n_in_y = '0; n_in_data = '0;
    w_in_v = 1'b0; w_in_x = '0; w_in_y = '0; w_in_data = '0;
    i_v    = 1'b0; i_x    = '0; i_y    = '0; i_data    = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset with every valid high
    idle();
    e_b = 1'b0; rst_n = 1'b0;
    n_in_v = 1'b1; w_in_v = 1'b1; i_v = 1'b1; w_in_x = 2'd3; i_x = 2'd1; i_y = 2'd1;
    tick(); tick();
    chk("rst_s_out_v", 64'(s_out_v), 64'(0));
    chk("rst_e_out_v", 64'(e_out_v), 64'(0));
    chk("rst_o_v",     64'(o_v),     64'(0));
    chk("rst_w_b",     64'(w_b),     64'(0));
    chk("rst_w_occ",   64'(w_occ),   64'(0));
    idle(); rst_n = 1'b1;
    tick();
    chk("idle_done", 64'(done), 64'(1));

    // West to east
    w_in_v = 1'b1; w_in_x = 2'd3; w_in_y = 2'd0; w_in_data = 32'hA5;
    tick(); idle();
    chk("we_occ1",   64'(w_occ),   64'(1));
    chk("we_ev0",    64'(e_out_v), 64'(0));
    tick();
    chk("we_ev1",    64'(e_out_v),    64'(1));
    chk("we_edata",  64'(e_out_data), 64'(32'hA5));
    chk("we_occ0",   64'(w_occ),      64'(0));

    // Backpressure: fill the FIFO while east is blocked
    e_b = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      w_in_v = 1'b1; w_in_x = 2'd2; w_in_y = 2'd0; w_in_data = 32'(k);
      tick();
    end
    chk("bp_w_b",   64'(w_b),        64'(1));
    chk("bp_occ4",  64'(w_occ),      64'(4));
    chk("bp_ev",    64'(e_out_v),    64'(1));
    chk("bp_edata", 64'(e_out_data), 64'(32'hA5));
    w_in_data = 32'd5;
    tick();
    chk("bp_occ_hold", 64'(w_occ),      64'(4));
    chk("bp_ehold",    64'(e_out_data), 64'(32'hA5));
    e_b = 1'b0;
    pi = 5;
    for (int c = 0; c < 12; c++) begin
      logic acc;
      acc = 1'b0;
      if (pi <= 6) begin
        w_in_v = 1'b1; w_in_data = 32'(pi);
        acc = !w_b;
      end else begin
        w_in_v = 1'b0;
      end
      tick();
      if (acc) pi++;
      if (e_out_v) rx.push_back(e_out_data);
    end
    idle();
    chk("bp_rx_count", 64'(rx.size()), 64'(6));
    for (int j = 0; j < 6; j++) chk($sformatf("bp_rx%0d", j), 64'(rx[j]), 64'(j + 1));
    chk("bp_occ0", 64'(w_occ), 64'(0));
    chk("bp_wb0",  64'(w_b),   64'(0));

    // Contention: north reg vs W head both wanting south
    n_in_v = 1'b1; n_in_x = 2'd1; n_in_y = 2'd3; n_in_data = 32'h11;
    w_in_v = 1'b1; w_in_x = 2'd1; w_in_y = 2'd0; w_in_data = 32'h77;
    tick(); idle();
    chk("ct_sv0",   64'(s_out_v), 64'(0));
    tick();
    chk("ct_sv1",   64'(s_out_v),    64'(1));
    chk("ct_sdN",   64'(s_out_data), 64'(32'h11));
    chk("ct_ov0",   64'(o_v),        64'(0));
    chk("ct_occ1",  64'(w_occ),      64'(1));
    tick();
    chk("ct_sv2",   64'(s_out_v),    64'(1));
    chk("ct_sdW",   64'(s_out_data), 64'(32'h77));
    chk("ct_occ0",  64'(w_occ),      64'(0));

    // Exit at this node from north
    n_in_v = 1'b1; n_in_x = 2'd1; n_in_y = 2'd1; n_in_data = 32'h3C;
    tick(); idle();
    chk("ex_sv0", 64'(s_out_v), 64'(0));
    tick();
    chk("ex_sv1",  64'(s_out_v),    64'(1));
    chk("ex_ov1",  64'(o_v),        64'(1));
    chk("ex_data", 64'(s_out_data), 64'(32'h3C));

    // Injection south (local exit) and east with/without backpressure
    i_v = 1'b1; i_x = 2'd1; i_y = 2'd1; i_data = 32'h55;
    #1;
    chk("inj_ack_s", 64'(i_ack), 64'(1));
    tick(); idle();
    chk("inj_sdata", 64'(s_out_data), 64'(32'h55));
    chk("inj_ov",    64'(o_v),        64'(1));
    i_v = 1'b1; i_x = 2'd2; i_y = 2'd0; i_data = 32'h66; e_b = 1'b1;
    #1;
    chk("inj_ack_eb", 64'(i_ack), 64'(0));
    e_b = 1'b0;
    #1;
    chk("inj_ack_e", 64'(i_ack), 64'(1));
    tick(); idle();
    chk("inj_ev",    64'(e_out_v),    64'(1));
    chk("inj_edata", 64'(e_out_data), 64'(32'h66));

    // Starvation: continuous W east traffic against an I east request
    w_in_v = 1'b1; w_in_x = 2'd2; w_in_y = 2'd0; w_in_data = 32'h100;
    tick();
    i_v = 1'b1; i_x = 2'd3; i_y = 2'd0; i_data = 32'h99;
    for (int c = 1; c <= 12; c++) begin
      w_in_data = 32'h100 + 32'(c);
      #1;
      chk($sformatf("boost_ack_c%0d", c), 64'(i_ack), 64'(BOOST && (c == 9)));
      tick();
    end
    idle();
    for (int c = 0; c < 8; c++) tick();
    chk("end_done", 64'(done),  64'(1));
    chk("end_occ",  64'(w_occ), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/torus_switch_fifo_bp.md
# torus_switch_fifo_bp

Parametrised successor to the single-shadow-register backpressured torus switch. It replaces the west-input shadow register with a configurable-depth synchronous FIFO and registers the north input. It arbitrates north, west and PE-injection traffic with fixed dimension-order routing, and honours east backpressure. It sits at each (X,Y) node of the unidirectional 2-D torus NoC, between the north/west ring links and the local PE.

## Interface
Parameters:
- X_W, 2, X address width
- Y_W, 2, Y address width
- D_W, 32, payload width
- X, 0, X coordinate of this node
- Y, 0, Y coordinate of this node
- W_DEPTH, 4, west FIFO depth; power of two, ≥2
- STARVE_LIMIT, 8, consecutive blocked inject cycles before boost; only used with the macro

Ports:
- clk, in, 1, clock
- rst_n, in, 1, reset; **one clock; reset is synchronous and active-low**
- n_in_v / n_in_x / n_in_y / n_in_data, in, 1/X_W/Y_W/D_W, north link
- w_in_v / w_in_x / w_in_y / w_in_data, in, 1/X_W/Y_W/D_W, west link
- i_v / i_x / i_y / i_data, in, 1/X_W/Y_W/D_W, PE injection
- e_b, in, 1, backpressure from east neighbour
- w_b, out, 1, backpressure to west neighbour
- i_ack, out, 1, injection accepted this cycle (combinational)
- o_v, out, 1, s_out carries a message destined for this node
- s_out_v / s_out_x / s_out_y / s_out_data, out, registered south link
- e_out_v / e_out_x / e_out_y / e_out_data, out, registered east link
- w_occ, out, $clog2(W_DEPTH)+1, west FIFO occupancy
- done, out, 1, switch and all inputs idle

## Operation
- North input register: captures the north link every cycle. Message goes south on the next edge unconditionally; the south link has no backpressure.
- West transfer: occurs when w_in_v && !w_b. w_b = (w_occ == W_DEPTH), driven from registers only, with no combinational path from e_b.
- Routing of the W FIFO head and of I: dest x≠X → east; dest x==X → south.
- East grant: W head first, then I. A grant requires !e_b.
- South grant: registered N first, then W head, then I.
- FIFO pop = W head granted. i_ack = I granted. Only one of W/I reaches each output.
- o_v <= selected south message valid && x==X && y==Y. Such a message also drives s_out_v.
- s_out registers load every cycle; s_out_v=0 when nothing is granted south.
- e_out registers load only when !e_b, otherwise they hold. With !e_b and no east grant, e_out_v <= 0.
- Simultaneous push and pop are allowed at any occupancy below full; w_occ is unchanged.
- done = !(all input valids | N reg valid | FIFO non-empty | s_out_v | e_out_v | o_v).
- Reset (rst_n=0 at an edge): FIFO emptied, N reg cleared, all output registers 0. Therefore s_out_v=e_out_v=o_v=0, w_b=0, w_occ=0, done=1 while inputs are idle. Reset mid-traffic drops in-flight messages; no partial state survives.

## Timing
- North in → s_out: 2 cycles.
- West in accepted at edge t: FIFO head at t, e_out/s_out valid after edge t+1 (latency 2) if granted.
- I → output: 1 cycle; i_ack is combinational in the same cycle.
- e_b high for k cycles: e_out frozen for k cycles, W head held, I east requests not acked.
- FIFO wrap: pointers are modulo W_DEPTH; the count distinguishes full from empty.

## Configuration
- TORUS_SW_INJ_BOOST_EN defined:
  - A counter increments each cycle i_v && !i_ack and clears on i_ack or !i_v.
  - When the count reaches STARVE_LIMIT, I outranks W for the next cycle on both outputs (N still wins south). The counter clears after the boost.
- Undefined: strict W-over-I priority; counter absent; I may starve indefinitely.

## Structure
- Shared package torus_pkg:
  - msg_t struct {x, y, data}
  - route enum {R_NONE, R_EAST, R_SOUTH}
  - a dor_route function
- Sub-module torus_fifo: parametrised sync FIFO with push/pop/full/empty/count and active-low sync reset.

## Test plan
- Reset: rst_n=0 for 2 cycles with all valids high → all outputs 0, w_b=0, w_occ=0. After release with idle inputs, done=1.
- West to east, X=1: message x=3,y=0,data=0xA5 at t → e_out_v=1, data 0xA5 after edge t+1; w_occ returns to 0.
- Backpressure, W_DEPTH=4: hold e_b=1 and stream 6 east messages → w_b rises after the 4th accept, w_occ=4, e_out held. Release e_b → all 6 messages delivered in order, none lost or duplicated.
- Contention: N reg valid (y≠Y) and W head x==X in the same cycle → N on s_out; W stays at FIFO head, granted south the next cycle.
- Exit, X=Y=1: north message x=1,y=1,data=0x3C → s_out_v=1, o_v=1 two cycles later.
- Boost (TORUS_SW_INJ_BOOST_EN, STARVE_LIMIT=8): continuous W east traffic plus I east request → i_ack on the 9th cycle. Without the macro, i_ack never asserts.
